// File: rtl/load_store_unit_if.sv
// CPU-side request/response bundle plus the data-RAM port of the load/store unit.
// master: the CPU memory stage together with the RAM (drives requests and read data).
// slave:  the load/store unit itself.
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  reqValid;
  logic                  reqReady;
  logic                  reqWrite;
  logic [1:0]            reqSize;
  logic                  reqSigned;
  logic [ADDR_WIDTH+2:0] reqAddr;
  logic [DATA_WIDTH-1:0] reqWriteData;
  logic                  respValid;
  logic [DATA_WIDTH-1:0] respData;
  logic                  respError;
  logic                  ramWrite;
  logic [ADDR_WIDTH-1:0] ramAddress;
  logic [DATA_WIDTH-1:0] ramWriteData;
  logic [DATA_WIDTH-1:0] ramReadData;

  modport master (
    output reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWriteData, ramReadData,
    input  reqReady, respValid, respData, respError, ramWrite, ramAddress, ramWriteData
  );

  modport slave (
    input  reqValid, reqWrite, reqSize, reqSigned, reqAddr, reqWriteData, ramReadData,
    output reqReady, respValid, respData, respError, ramWrite, ramAddress, ramWriteData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte-addressed sub-word loads/stores into whole-word accesses
// on a 64-bit word-addressed RAM with a registered read port. Narrow stores use
// read-modify-write. All outputs are registered.
// Optional feature macro: LSU_ALIGN_CHECK_EN -- when defined, misaligned requests are
// trapped with respError; when undefined, low address bits are cleared instead.
module load_store_unit #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input logic              clk,
  input logic              resetN,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StRead, StMerge, StWrite, StResp} state_e;

  state_e                state;
  logic                  write_q;
  logic [1:0]            size_q;
  logic                  signed_q;
  logic [2:0]            offset_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_error;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  ram_write;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign bus.reqReady     = req_ready;
  assign bus.respValid    = resp_valid;
  assign bus.respError    = resp_error;
  assign bus.respData     = resp_data;
  assign bus.ramWrite     = ram_write;
  assign bus.ramAddress   = ram_address;
  assign bus.ramWriteData = ram_wdata;

  logic [2:0]            low_mask;
  logic [ADDR_WIDTH+2:0] req_addr;
  logic                  req_misaligned;

  // Decode alignment of the incoming request (only consumed on accept).
  always_comb begin
    low_mask       = 3'b000;
    req_addr       = bus.reqAddr;
    req_misaligned = 1'b0;
    unique case (bus.reqSize)
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
`ifdef LSU_ALIGN_CHECK_EN
    req_misaligned = |(bus.reqAddr[2:0] & low_mask);
`else
    // No trapping: silently round the address down to the access size.
    req_addr = bus.reqAddr & ~{{ADDR_WIDTH{1'b0}}, low_mask};
`endif
  end

  logic [5:0]            shamt;
  logic [7:0]            lane_base;
  logic [7:0]            lane_en;
  logic [DATA_WIDTH-1:0] lane_mask;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_value;

  // Lane selection, store merge and load extraction from the RAM read word.
  always_comb begin
    shamt     = {offset_q, 3'b000};
    lane_base = 8'hff;
    unique case (size_q)
      2'd0:    lane_base = 8'h01;
      2'd1:    lane_base = 8'h03;
      2'd2:    lane_base = 8'h0f;
      default: lane_base = 8'hff;
    endcase
    lane_en   = lane_base << offset_q;
    lane_mask = '0;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{lane_en[i]}};
    end
    merged  = (bus.ramReadData & ~lane_mask) | ((data_q << shamt) & lane_mask);
    shifted = bus.ramReadData >> shamt;
    unique case (size_q)
      2'd0:    load_value = signed_q ? {{56{shifted[7]}}, shifted[7:0]}
                                     : {56'd0, shifted[7:0]};
      2'd1:    load_value = signed_q ? {{48{shifted[15]}}, shifted[15:0]}
                                     : {48'd0, shifted[15:0]};
      2'd2:    load_value = signed_q ? {{32{shifted[31]}}, shifted[31:0]}
                                     : {32'd0, shifted[31:0]};
      default: load_value = shifted;
    endcase
  end

  // Control FSM; every output is registered alongside the state transition.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= StIdle;
      write_q     <= 1'b0;
      size_q      <= 2'd0;
      signed_q    <= 1'b0;
      offset_q    <= 3'd0;
      data_q      <= '0;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_error  <= 1'b0;
      resp_data   <= '0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_wdata   <= '0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.reqValid) begin
            write_q     <= bus.reqWrite;
            size_q      <= bus.reqSize;
            signed_q    <= bus.reqSigned;
            offset_q    <= req_addr[2:0];
            data_q      <= bus.reqWriteData;
            ram_address <= req_addr[ADDR_WIDTH+2:3];
            req_ready   <= 1'b0;
            if (req_misaligned) begin
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_data  <= '0;
              state      <= StResp;
            end else if (bus.reqWrite && bus.reqSize == 2'd3) begin
              // Full-word store needs no read-back.
              ram_wdata <= bus.reqWriteData;
              ram_write <= 1'b1;
              state     <= StWrite;
            end else begin
              state <= StRead;
            end
          end
        end
        StRead: begin
          // RAM read data for the latched address arrives next cycle.
          state <= StMerge;
        end
        StMerge: begin
          if (write_q) begin
            ram_wdata <= merged;
            ram_write <= 1'b1;
            state     <= StWrite;
          end else begin
            resp_data  <= load_value;
            resp_error <= 1'b0;
            resp_valid <= 1'b1;
            state      <= StResp;
          end
        end
        StWrite: begin
          ram_write  <= 1'b0;
          resp_data  <= '0;
          resp_error <= 1'b0;
          resp_valid <= 1'b1;
          state      <= StResp;
        end
        StResp: begin
          req_ready   <= 1'b1;
          resp_error  <= 1'b0;
          ram_address <= '0;
          state       <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized traffic
// checked against a byte-array memory model. Also models the registered-read RAM.
module tb_load_store_unit;

  logic clk;
  logic resetN;

  load_store_unit_if bus ();

  load_store_unit dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with registered read port.
  logic [63:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus.ramWrite) mem[bus.ramAddress] <= bus.ramWriteData;
    bus.ramReadData <= mem[bus.ramAddress];
  end

  // Reference model: flat byte memory covering byte addresses 0..255.
  logic [7:0] mb [0:255];

  int checks;
  int passes;
  int acc_cnt;
  int resp_cnt;
  int wr_cnt;
  logic [11:0] last_wr_addr;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.reqValid && bus.reqReady) acc_cnt++;
    if (bus.respValid) resp_cnt++;
    if (bus.ramWrite) begin
      wr_cnt++;
      last_wr_addr = bus.ramAddress;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(bus.reqReady), 64'd1);
    check({tag, "_resp_valid"}, 64'(bus.respValid), 64'd0);
    check({tag, "_resp_data"}, bus.respData, 64'd0);
    check({tag, "_resp_error"}, 64'(bus.respError), 64'd0);
    check({tag, "_ram_write"}, 64'(bus.ramWrite), 64'd0);
    check({tag, "_ram_address"}, 64'(bus.ramAddress), 64'd0);
    check({tag, "_ram_wdata"}, bus.ramWriteData, 64'd0);
  endtask

  // Issue one request (called #1 after a rising edge) and check it end to end.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [14:0] a, input logic [63:0] d, input logic keep,
                       output logic [63:0] rd, output logic er);
    logic [63:0] exp_d;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    int          nb;
    int          base;
    logic [14:0] ea;
    bit          got;
    bus.reqValid     = 1'b1;
    bus.reqWrite     = w;
    bus.reqSize      = sz;
    bus.reqSigned    = sg;
    bus.reqAddr      = a;
    bus.reqWriteData = d;
    rd  = '0;
    er  = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.reqReady) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("accept_seen", 64'(got), 64'd1);
    if (!got) return;

    nb    = 1 << sz;
    exp_e = 1'b0;
    ea    = a;
`ifdef LSU_ALIGN_CHECK_EN
    if ((int'(a) % nb) != 0) exp_e = 1'b1;
`else
    ea = a & ~15'(nb - 1);
`endif
    base  = int'(ea[7:0]);
    exp_d = '0;
    if (exp_e) begin
      exp_lat = 1;
    end else if (w) begin
      for (int i = 0; i < nb; i++) mb[base + i] = d[8*i +: 8];
      exp_lat = (sz == 2'd3) ? 2 : 4;
    end else begin
      for (int i = 0; i < nb; i++) exp_d[8*i +: 8] = mb[base + i];
      if (sg && sz != 2'd3 && exp_d[8*nb-1]) begin
        for (int i = nb; i < 8; i++) exp_d[8*i +: 8] = 8'hff;
      end
      exp_lat = 3;
    end

    @(posedge clk);
    #1;
    if (!keep) bus.reqValid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.respValid) begin
        got = 1'b1;
        break;
      end
      check("busy_ready_low", 64'(bus.reqReady), 64'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("resp_seen", 64'(got), 64'd1);
    if (!got) return;
    check("resp_ready_low", 64'(bus.reqReady), 64'd0);
    check("latency", 64'(lat), 64'(exp_lat));
    check("resp_data", bus.respData, exp_d);
    check("resp_error", 64'(bus.respError), 64'(exp_e));
    rd = bus.respData;
    er = bus.respError;
    @(posedge clk);
    #1;
    check("idle_ready", 64'(bus.reqReady), 64'd1);
    check("idle_ram_addr", 64'(bus.ramAddress), 64'd0);
    check("resp_single_pulse", 64'(bus.respValid), 64'd0);
  endtask

  logic [63:0] rd;
  logic        er;
  int          wb;
  int          a0;
  int          r0;

  initial begin
    checks = 0;
    passes = 0;
    acc_cnt = 0;
    resp_cnt = 0;
    wr_cnt = 0;
    last_wr_addr = '0;
    resetN = 1'b0;
    bus.reqValid = 1'b0;
    bus.reqWrite = 1'b0;
    bus.reqSize = 2'd0;
    bus.reqSigned = 1'b0;
    bus.reqAddr = '0;
    bus.reqWriteData = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    // Fill the modelled region with known data.
    for (int w = 0; w < 32; w++) begin
      issue(1'b1, 2'd3, 1'b0, 15'(w * 8), {$urandom, $urandom}, 1'b0, rd, er);
    end

    // Double store then double load.
    wb = wr_cnt;
    issue(1'b1, 2'd3, 1'b0, 15'h10, 64'hDEADBEEFCAFEF00D, 1'b0, rd, er);
    check("dstore_write_pulses", 64'(wr_cnt - wb), 64'd1);
    check("dstore_ram_addr", 64'(last_wr_addr), 64'd2);
    issue(1'b0, 2'd3, 1'b0, 15'h10, 64'd0, 1'b0, rd, er);
    check("dload_value", rd, 64'hDEADBEEFCAFEF00D);

    // Byte read-modify-write.
    issue(1'b1, 2'd3, 1'b0, 15'h10, 64'h1122334455667788, 1'b0, rd, er);
    issue(1'b1, 2'd0, 1'b0, 15'h13, 64'h00000000000000AB, 1'b0, rd, er);
    check("byte_store_word", mem[2], 64'h11223344AB667788);
    issue(1'b0, 2'd0, 1'b0, 15'h13, 64'd0, 1'b0, rd, er);
    check("byte_load", rd, 64'h00000000000000AB);

    // Sign/zero extension.
    issue(1'b1, 2'd3, 1'b0, 15'h20, 64'h800000000000FF80, 1'b0, rd, er);
    issue(1'b0, 2'd0, 1'b1, 15'h20, 64'd0, 1'b0, rd, er);
    check("sbyte_load", rd, 64'hFFFFFFFFFFFFFF80);
    issue(1'b0, 2'd0, 1'b0, 15'h20, 64'd0, 1'b0, rd, er);
    check("ubyte_load", rd, 64'h0000000000000080);
    issue(1'b0, 2'd2, 1'b1, 15'h24, 64'd0, 1'b0, rd, er);
    check("sword_load", rd, 64'hFFFFFFFF80000000);

    // Misaligned half load.
    wb = wr_cnt;
    issue(1'b0, 2'd1, 1'b0, 15'h21, 64'd0, 1'b0, rd, er);
`ifdef LSU_ALIGN_CHECK_EN
    check("misaligned_error", 64'(er), 64'd1);
    check("misaligned_data", rd, 64'd0);
`else
    check("rounded_error", 64'(er), 64'd0);
    check("rounded_data", rd, 64'h000000000000FF80);
`endif
    check("misaligned_no_write", 64'(wr_cnt - wb), 64'd0);

    // Reset during MERGE of a narrow store.
    wb = wr_cnt;
    bus.reqValid = 1'b1;
    bus.reqWrite = 1'b1;
    bus.reqSize = 2'd0;
    bus.reqSigned = 1'b0;
    bus.reqAddr = 15'h30;
    bus.reqWriteData = 64'h5A;
    @(negedge clk);
    check("rst_test_accept", 64'(bus.reqReady), 64'd1);
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    @(posedge clk);
    #1;
    resetN = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetN = 1'b1;
    @(posedge clk);
    #1;
    check("midreset_ready_after", 64'(bus.reqReady), 64'd1);
    check("midreset_no_write", 64'(wr_cnt - wb), 64'd0);
    issue(1'b0, 2'd3, 1'b0, 15'h30, 64'd0, 1'b0, rd, er);

    // Randomized traffic against the byte model.
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom), 2'($urandom), 1'($urandom), 15'($urandom_range(0, 255)),
            {$urandom, $urandom}, 1'b0, rd, er);
    end

    // reqValid held high with alternating loads and stores.
    a0 = acc_cnt;
    r0 = resp_cnt;
    for (int i = 0; i < 24; i++) begin
      issue(1'(i % 2), 2'($urandom), 1'($urandom), 15'($urandom_range(0, 255)),
            {$urandom, $urandom}, (i != 23), rd, er);
    end
    @(negedge clk);
    check("stream_accepts", 64'(acc_cnt - a0), 64'd24);
    check("stream_responses", 64'(resp_cnt - r0), 64'd24);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the CPU memory stage and the 64-bit word-addressed data RAM, converting byte-addressed sub-word loads and stores into whole-word RAM accesses. Loads are extracted and optionally sign-extended. Narrow stores use read-modify-write, because the RAM only writes whole words. One request is handled at a time under a valid/ready handshake, and each request gets a single-cycle response pulse.

## Interface
Parameters:
- DATA_WIDTH, 64: RAM word width; fixed at 64 (8 byte lanes).
- ADDR_WIDTH, 12: RAM word-address width; byte address is ADDR_WIDTH+3 bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- reqValid  in  1  request present.
- reqReady  out  1  unit can accept; high only in IDLE.
- reqWrite  in  1  1 = store, 0 = load.
- reqSize  in  2  access size: 0 = byte, 1 = half, 2 = word (32 bit), 3 = double.
- reqSigned  in  1  loads only: sign-extend the result.
- reqAddr  in  ADDR_WIDTH+3  byte address, little-endian.
- reqWriteData  in  64  store data, right-justified.
- respValid  out  1  one-cycle completion pulse.
- respData  out  64  load result (0 for stores).
- respError  out  1  misaligned request; qualified by respValid.
- ramWrite  out  1  RAM write enable.
- ramAddress  out  ADDR_WIDTH  RAM word address, equal to reqAddr[ADDR_WIDTH+2:3].
- ramWriteData  out  64  RAM write data.
- ramReadData  in  64  RAM registered read data; valid the cycle after ramAddress is presented.

## Operation
- Accept occurs when reqValid && reqReady.
- On accept, the unit registers reqWrite, reqSize, reqSigned, reqAddr and reqWriteData. Inputs are not sampled again until the next accept.
- States are IDLE, READ, MERGE, WRITE, RESP. All outputs are registered or decoded from state only; there are no input-to-output combinational paths.
- Load: IDLE → READ → MERGE → RESP → IDLE.
  - In MERGE the unit selects the lane at byte offset a = addr[2:0] and shifts it right by 8·a.
  - It then zero-extends, or sign-extends when the latched reqSigned is set, from 8, 16 or 32 bits into the respData register.
- Store, size 3: IDLE → WRITE → RESP → IDLE. In WRITE, ramWriteData = latched data.
- Store, size 0–2: IDLE → READ → MERGE → WRITE → RESP → IDLE.
  - In MERGE, merged = (ramReadData & ~mask) | ((data << 8·a) & mask), where mask covers 1, 2 or 4 bytes starting at lane a.
  - merged is registered and written in WRITE.
  - Bytes outside the mask are preserved exactly.
- RAM control: ramWrite = 1 only in WRITE. ramAddress is driven from the latched address in every state except IDLE, where it is 0.
- Alignment: a request is misaligned if addr is not a multiple of its size (see Configuration). A misaligned request goes IDLE → RESP with respError = 1 and respData = 0; ramWrite is never asserted for it.
- RESP: respValid = 1 for exactly one cycle. There is no response back-pressure.
- Reset mid-operation: any in-flight access is abandoned and RAM contents are not guaranteed for an abandoned store. ramWrite drops asynchronously.

## Timing
- Reset values: state IDLE, reqReady 1, respValid 0, respData 0, respError 0, ramWrite 0, ramAddress 0, ramWriteData 0.
- Accept at cycle T; respValid occurs at:
  - load: T+3
  - double store: T+2
  - narrow store: T+4
  - misaligned: T+1
- reqReady is low from T+1 until the cycle after respValid, when the unit is back in IDLE. Minimum request spacing is therefore latency + 1.
- respData holds its value until the next load response. After a store response it reads 0.
- A store completes in WRITE before RESP. A load accepted immediately after a store response reads the stored data.

## Configuration
- LSU_ALIGN_CHECK_EN defined: misaligned requests are trapped as described above, with respError = 1.
- LSU_ALIGN_CHECK_EN undefined:
  - respError is tied to 0 and no request is ever trapped.
  - Low address bits below the access size are forced to 0 before use: half clears bit 0, word clears [1:0], double clears [2:0].

## Test plan
- Double store 0xDEADBEEFCAFEF00D to byte address 0x10, then a double load from 0x10 → ramWrite pulses once at ramAddress 2; load respData = 0xDEADBEEFCAFEF00D at T+3.
- Word at 0x10 = 0x1122334455667788; byte store 0xAB to 0x13 → word becomes 0x11223344AB667788; byte load from 0x13 returns 0xAB.
- Word 0x80000000_0000FF80 at 0x20:
  - signed byte load from 0x20 → 0xFFFFFFFFFFFFFF80
  - unsigned byte load from 0x20 → 0x80
  - signed word load from 0x24 → 0xFFFFFFFF80000000
- Half load from 0x21 (misaligned):
  - with LSU_ALIGN_CHECK_EN: respError = 1 at T+1, respData = 0, no RAM write.
  - without it: the request behaves as an address of 0x20, with no error.
- Assert resetN low during MERGE of a narrow store → ramWrite never asserts, outputs return to reset values immediately, and reqReady = 1 after release.
- Hold reqValid high continuously with alternating load and store requests → reqReady is low throughout every busy interval, and each accept produces exactly one respValid pulse.
